serial_adder_nand: RTL and testbench
====================================

Name: serial_adder_nand

Overview:
- Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- Per-bit sum/carry comes from a single full-adder cell built only from 2-input nand primitives. This is the gate-level successor to the team's NAND half adder.
- Used where area matters more than latency. Sits between a register-file read and a result register under a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when idle or in DONE
- A  input  WIDTH  operand A; captured on accepted start
- B  input  WIDTH  operand B; captured on accepted start
- Cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result becomes valid
- Sum  output  WIDTH  result; holds last completed value
- Carry  output  1  carry-out of MSB; holds last completed value

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE; busy=0, done=0, Sum=0, Carry=0. Internal operand shift registers, partial sum, bit counter and carry flop all cleared. rst has priority over every other input.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 captures A, B and Cin; carry flop<=Cin; cnt<=0; next state RUN. Otherwise stay.
  - RUN: on each edge, the full adder combines bit cnt of A, bit cnt of B and the carry flop. The sum bit goes into the partial-sum register at position cnt, the carry flop takes the cell's carry, and cnt increments. When cnt==WIDTH-1 is processed: Sum<=completed partial sum, Carry<=final carry, next state DONE. start is ignored in RUN.
  - DONE: lasts exactly one cycle; done=1. start=1 behaves as in IDLE (capture, go RUN), giving back-to-back operation with no idle cycle. Otherwise go to IDLE.
- busy=1 exactly when state==RUN. done=1 exactly when state==DONE. Both are registered, glitch-free.
- Latency: start high in cycle 0 gives busy high in cycles 1..WIDTH and done high in cycle WIDTH+1. Sum/Carry are valid from cycle WIDTH+1 and held until the next completion.
- Sum/Carry never show partial results; they change only on the completing edge.
- A/B/Cin changes after capture have no effect on the operation in flight.
- cnt width is clog2(WIDTH). It does not wrap during RUN; it is reloaded on each accepted start.
- Full-adder cell: 9 nand primitives (two cascaded NAND half-adder XOR structures, carry = nand of the two intermediate nands). No behavioural + operator anywhere in the datapath. Sequential control uses ordinary always blocks.
- rst asserted mid-RUN aborts the operation. Sum/Carry return to 0 (the previous result is lost) and no done pulse is issued.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output Ovf, 1 bit. It is the signed overflow of the completed add: carry into the MSB XOR carry out of the MSB.
  - The carry into the MSB is sampled while processing bit WIDTH-1.
  - Ovf is updated on the same edge as Sum, held with it, and reset to 0.
- Undefined: port Ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, A=0xFF, B=0x01, Cin=0, start in cycle 0 -> busy high cycles 1..8, done pulse cycle 9, Sum=0x00, Carry=1.
- A=0x5A, B=0x3C, Cin=1 -> Sum=0x97, Carry=0 at done. A and B are changed to 0x00 during busy; the result must be unchanged.
- start re-asserted during cycles 1..8 of an operation -> ignored; exactly one done pulse, at cycle 9. start asserted in the done cycle with A=0x10, B=0x20 -> next done 9 cycles later, Sum=0x30; the previous Sum is held in between.
- rst=1 in cycle 4 of an operation -> next cycle busy=0, done=0, Sum=0, Carry=0; no done pulse afterwards.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 gives Sum=0x80, Carry=0, Ovf=1. 0xFF+0x01 gives Carry=1, Ovf=0. 0x80+0x80 gives Sum=0x00, Carry=1, Ovf=1.
- WIDTH=16 random sweep of 1000 operations versus a reference A+B+Cin -> every Sum/Carry matches. Each done falls exactly 17 cycles after its accepted start.

Source files
------------

// File: rtl/serial_adder_nand.sv
// Bit-serial adder (LSB first) built around a 9-NAND full-adder cell, with a start/done handshake.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_ADDER_OVF_EN.

module serial_adder_nand_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    logic n1, n2, n3, x;
    logic m1, m2, m3;

    // First half adder: x = a ^ b, n1 = ~(a & b)
    nand g1 (n1, a_i, b_i);
    nand g2 (n2, a_i, n1);
    nand g3 (n3, b_i, n1);
    nand g4 (x,  n2,  n3);

    // Second half adder: s = x ^ c, m1 = ~(x & c)
    nand g5 (m1, x,   c_i);
    nand g6 (m2, x,   m1);
    nand g7 (m3, c_i, m1);
    nand g8 (s_o, m2, m3);

    nand g9 (co_o, n1, m1);
endmodule

module serial_adder_nand #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s, fa_c;
    logic accept;
    logic last;

    assign accept = start && (state_q != S_RUN);
    assign last   = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    serial_adder_nand_fa u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_c)
    );

    // State register; busy/done are registered from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (last)   state_d = S_DONE;
            S_DONE:  state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // Operands shift right so the cell always sees bit cnt at position 0.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (accept) begin
            a_d     = A;
            b_d     = B;
            carry_d = Cin;
            cnt_d   = '0;
            psum_d  = '0;
        end else if (state_q == S_RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_c;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    psum_d[i] = fa_s;
                end
            end
            if (last) begin
                sum_d  = psum_d;
                cout_d = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                ovf_d  = carry_q ^ fa_c;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign Sum   = sum_q;
    assign Carry = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign Ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder_nand.sv
// Scoreboard bench for serial_adder_nand: driver pushes expected results, negedge monitor checks them.
module tb_serial_adder_nand;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst, start, Cin;
    logic [W-1:0] A, B;
    logic         busy, done, Carry;
    logic [W-1:0] Sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         Ovf;
    logic         held_o;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        int unsigned  acc;
    } exp_t;

    exp_t         q[$];
    int unsigned  nvec = 0;
    int unsigned  nerr = 0;
    int unsigned  cyc  = 0;
    logic [W-1:0] held_sum;
    logic         held_c;

    serial_adder_nand #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Carry (Carry)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer addition; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input int unsigned acc);
        logic [W:0] full;
        exp_t       e;
        full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.sum   = full[W-1:0];
        e.carry = full[W];
        e.ovf   = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        e.acc   = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", Sum, e.sum);
                    chk("carry", Carry, e.carry);
                    chk("latency", cyc - e.acc, W);
                    held_sum = e.sum;
                    held_c   = e.carry;
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf", Ovf, e.ovf);
                    held_o = e.ovf;
`endif
                end
            end else begin
                chk("hold_sum", Sum, held_sum);
                chk("hold_carry", Carry, held_c);
`ifdef SERIAL_ADDER_OVF_EN
                chk("hold_ovf", Ovf, held_o);
`endif
            end
        end
    end

    // Call just after a rising edge with the DUT idle or in its done cycle.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        A = a; B = b; Cin = c; start = 1'b1;
        @(posedge clk); #1;
        q.push_back(model(a, b, c, cyc));
        start = 1'b0;
    endtask

    task automatic to_done();
        repeat (W) @(posedge clk);
        #1;
    endtask

    task automatic to_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        held_sum = '0; held_c = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        held_o = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_carry", Carry, 0);
        rst = 1'b0;
        to_idle();

        // 0xFF + 0x01: busy across cycles 1..W, single done after
        issue(8'hFF, 8'h01, 1'b0);
        for (int k = 1; k <= int'(W); k++) begin
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            @(posedge clk); #1;
        end
        chk("busy_in_done", busy, 0);
        chk("done_pulse", done, 1);
        to_idle();
        chk("done_low", done, 0);
        chk("busy_idle", busy, 0);

        // Operand changes after capture must not matter
        issue(8'h5A, 8'h3C, 1'b1);
        A = '0; B = '0; Cin = 1'b0;
        to_done();
        to_idle();

        // start held through RUN is ignored; still high in DONE gives back-to-back
        issue(8'h11, 8'h22, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        repeat (W - 1) @(posedge clk);
        #1;
        issue(8'h10, 8'h20, 1'b0);
        to_done();
        to_idle();

        // Reset in cycle 4 aborts the operation and clears the result
        issue(8'hC3, 8'h5E, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        q.delete();
        held_sum = '0; held_c = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        held_o = 1'b0;
`endif
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", Sum, 0);
        chk("abort_carry", Carry, 0);
        rst = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;

        // Overflow corner cases
        issue(8'h7F, 8'h01, 1'b0); to_done(); to_idle();
        issue(8'hFF, 8'h01, 1'b0); to_done(); to_idle();
        issue(8'h80, 8'h80, 1'b0); to_done(); to_idle();
        issue(8'h00, 8'h00, 1'b1); to_done(); to_idle();

        // Random sweep with noisy inputs during RUN and random back-to-back
        for (int n = 0; n < 300; n++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)));
            for (int k = 0; k < int'(W); k++) begin
                @(posedge clk); #1;
                if (k < int'(W) - 1) begin
                    start = 1'($urandom_range(1, 0));
                    A     = W'($urandom);
                    B     = W'($urandom);
                    Cin   = 1'($urandom_range(1, 0));
                end else begin
                    start = 1'b0;
                end
            end
            if ($urandom_range(1, 0) == 0) begin
                to_idle();
                repeat ($urandom_range(2, 0)) @(posedge clk);
                #1;
            end
        end
        to_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
